cell_pos_reader: RTL
====================

# cell_pos_reader

Read sequencer and stream adapter that sits directly downstream of one per-cell position memory (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = `{posz, posy, posx}`). On a `start` pulse it reads the particle count, then fetches each particle position in order. It presents the positions to the force-evaluation / motion-update pipeline as a valid/ready stream with full backpressure support. Read credits and a small output FIFO absorb the memory latency so that sustained throughput is one particle per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 96: position word width, `{posz, posy, posx}`, 32 bits each.
- `ADDR_WIDTH`, 8: cell memory address width.
- `PARTICLE_NUM`, 220: memory depth in words. The maximum usable particle count is `PARTICLE_NUM-1`.
- `FIFO_DEPTH`, 4: output buffer depth. Must be at least 3 (power of two).

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle request to stream the cell. Ignored while `busy`.
- `busy`, out, 1: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`, out, 1: one-cycle pulse after the last particle is accepted downstream, or after a zero count is read.
- `particle_count`, out, ADDR_WIDTH: count latched from address 0, after clamping.
- `cell_addr`, out, ADDR_WIDTH: registered memory address.
- `cell_rden`, out, 1: registered memory read enable.
- `cell_q`, in, DATA_WIDTH: memory read data. Valid 2 cycles after the corresponding `cell_addr`/`cell_rden` cycle.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready.
- `out_pos`, out, DATA_WIDTH: particle position.
- `out_idx`, out, ADDR_WIDTH: particle address, 1..count.
- `out_last`, out, 1: high with the final particle.

## Operation
- FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH.
- IDLE:
  - On `start`, go to RD_CNT.
- RD_CNT:
  - Drive `cell_addr=0`, `cell_rden=1` for one cycle.
  - Go to WAIT_CNT.
- WAIT_CNT:
  - Wait 2 cycles, then latch `cell_q[ADDR_WIDTH-1:0]` as the count.
  - If the count exceeds `PARTICLE_NUM-1`, clamp it to `PARTICLE_NUM-1`.
  - If count is 0, go to FINISH. Otherwise go to STREAM with the read pointer at 1.
- STREAM:
  - Issue a read (`cell_rden=1`, `cell_addr`=pointer) in any cycle where `occupancy + inflight + (pop ? -1 : 0) < FIFO_DEPTH`.
  - After each read, increment the pointer.
  - Once the pointer has issued address `count`, go to DRAIN.
- Read pipeline:
  - A 2-stage shift register tracks which reads are in flight. It carries the valid bit and the index.
  - Returning `cell_q` is pushed into the FIFO with its index. `out_last` is set when the index equals `count`.
- FIFO:
  - Push and pop in the same cycle is allowed, and occupancy is unchanged.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
- DRAIN:
  - Stay here until the FIFO is empty, nothing is in flight, and the final beat (`out_last`) has been accepted.
  - Then go to FINISH.
- FINISH:
  - Pulse `done` for one cycle, then return to IDLE.
- `cell_rden` is 0 in all states except the issue cycles. `cell_addr` holds its last value when not reading.
- Stream rules:
  - Once `out_valid` is asserted, `out_pos`, `out_idx` and `out_last` stay stable until `out_valid && out_ready`.
  - `out_valid` never depends combinationally on `out_ready`.
- The block never writes the memory. The memory's `wren` is tied low by the parent.

## Timing
- Reset values of all outputs: `busy`=0, `done`=0, `particle_count`=0, `cell_addr`=0, `cell_rden`=0, `out_valid`=0, `out_pos`=0, `out_idx`=0, `out_last`=0. FSM resets to IDLE, and FIFO and pointers are cleared.
- `start` is sampled in cycle T.
- Count read:
  - Count address driven in T+1, count data valid in T+3.
  - `busy` goes high in T+1.
- First particle:
  - First particle address driven in T+4, data in T+6.
  - `out_valid` goes high in T+7.
- With `out_ready` held high, one beat is produced per cycle. Particle k appears in T+6+k.
- `done` is asserted the cycle after the last handshake.
- Stall behaviour:
  - With `out_ready` low, at most `FIFO_DEPTH` reads are outstanding, then issue stops.
  - Issue resumes the cycle after the first pop.
- Reset asserted mid-operation:
  - Takes effect immediately (asynchronous). In-flight read data is discarded.
  - Any later `cell_q` is ignored, because the in-flight tracking shift register has been cleared.
- `start` is ignored whenever `busy` is high, and in the cycle `done` pulses.

## Structure
- Shared package `md_pos_pkg` holds:
  - the FSM state enum;
  - the `READ_LATENCY` = 2 constant;
  - the position word field offsets (x [31:0], y [63:32], z [95:64]).
- One sub-module: `pos_stream_fifo`, a synchronous FIFO with parameterised width and depth. It exposes occupancy and uses first-word-fall-through output registers.

## Test plan
- Count=5, `out_ready` held high:
  - 5 beats with `out_idx` 1..5 in cycles T+7..T+11.
  - `out_last` is set only on idx 5.
  - `done` pulses in T+12.
- Count=0:
  - No `out_valid`.
  - `done` in T+4, `busy` low afterward.
- Count=200, `out_ready` random 50%:
  - All 200 positions arrive in order, each matching memory contents.
  - The FIFO never overflows.
  - Outstanding reads plus occupancy never exceed 4.
- Count word=255 with `PARTICLE_NUM`=220:
  - `particle_count`=219.
  - The last beat has idx 219.
  - No read to address ≥220.
- `out_ready` low for 20 cycles mid-stream:
  - Exactly 4 reads are issued, then `cell_rden` stays 0.
  - The held beat is stable throughout.
  - The stream resumes without loss.
- `rst_n` pulsed low during STREAM with reads in flight:
  - All outputs return to their reset values.
  - Returning data is ignored.
  - A new `start` then streams the cell correctly from idx 1.

Source files
------------

// File: rtl/md_pos_pkg.sv
// Shared definitions for the cell position read path: sequencer states,
// memory read latency and the {posz, posy, posx} word layout.
package md_pos_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        FINISH
    } rd_state_t;

    localparam int READ_LATENCY = 2;

    localparam int POS_FIELD_W = 32;
    localparam int POS_X_LSB   = 0;
    localparam int POS_Y_LSB   = 32;
    localparam int POS_Z_LSB   = 64;
endpackage

// File: rtl/pos_stream_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head; occupancy
// counts the head register plus the entries queued behind it.
module pos_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   ram_cnt;
    logic             do_pop, load_out, ram_empty, ram_wr, ram_rd;

    assign do_pop    = pop && valid;
    assign load_out  = !valid || do_pop;
    assign ram_empty = (ram_cnt == '0);
    assign ram_rd    = load_out && !ram_empty;
    // A push into an empty queue while the head is free bypasses the queue.
    assign ram_wr    = push && !(load_out && ram_empty);
    assign occupancy = ram_cnt + {{PTR_W{1'b0}}, valid};

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            valid   <= 1'b0;
            dout    <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ram_cnt <= ram_cnt + (PTR_W + 1)'(ram_wr) - (PTR_W + 1)'(ram_rd);
            if (load_out) begin
                if (!ram_empty) begin
                    dout  <= mem[rd_ptr];
                    valid <= 1'b1;
                end else if (push) begin
                    dout  <= din;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && (occupancy >= ($clog2(DEPTH) + 1)'(DEPTH))));
endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count and then every particle position of one cell memory,
// streaming them out as valid/ready beats with credit-limited read issue.
module cell_pos_reader
    import md_pos_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] cell_addr,
    output logic                  cell_rden,
    input  logic [DATA_WIDTH-1:0] cell_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last
);
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W  = OCC_W + 2;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(PARTICLE_NUM - 1);

    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        if ({1'b0, raw} > MAX_COUNT) begin
            return MAX_COUNT[ADDR_WIDTH-1:0];
        end
        return raw;
    endfunction

    rd_state_t             state, state_next;
    logic [ADDR_WIDTH:0]   ptr, ptr_next;
    logic [1:0]            wcnt, wcnt_next;
    logic [ADDR_WIDTH-1:0] addr_next, count_next, count_rd;
    logic                  rden_next;

    logic                  stream_rd, pop, credit_ok, drain_done;
    logic [1:0]            inflight;
    logic [OCC_W-1:0]      occupancy;
    logic [CRED_W-1:0]     credit_used, credit_lim;

    logic                  vld_p1, vld_p2, last_p2;
    logic [ADDR_WIDTH-1:0] idx_p1, idx_p2;
    logic [ENTRY_W-1:0]    fifo_dout;

    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    // Address 0 is the count read; only particle reads enter the tracking pipe.
    assign stream_rd   = cell_rden && (cell_addr != '0);
    assign pop         = out_valid && out_ready;
    assign inflight    = {1'b0, stream_rd} + {1'b0, vld_p1} + {1'b0, vld_p2};
    assign credit_used = CRED_W'(occupancy) + CRED_W'(inflight);
    assign credit_lim  = CRED_W'(FIFO_DEPTH) + CRED_W'(pop);
    assign credit_ok   = (credit_used < credit_lim);
    assign drain_done  = pop && out_last && (occupancy == OCC_W'(1)) && (inflight == 2'd0);
    assign count_rd    = clamp_count(cell_q[ADDR_WIDTH-1:0]);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wcnt_next  = wcnt;
        addr_next  = cell_addr;
        rden_next  = 1'b0;
        count_next = particle_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RD_CNT;
                    addr_next  = '0;
                    rden_next  = 1'b1;
                end
            end
            RD_CNT: begin
                state_next = WAIT_CNT;
                wcnt_next  = '0;
            end
            WAIT_CNT: begin
                wcnt_next = wcnt + 2'd1;
                if (wcnt == 2'(READ_LATENCY - 1)) begin
                    count_next = count_rd;
                    if (count_rd == '0) begin
                        state_next = FINISH;
                    end else begin
                        // Particle 1 is issued on the way into STREAM.
                        state_next = STREAM;
                        addr_next  = ADDR_WIDTH'(1);
                        rden_next  = 1'b1;
                        ptr_next   = (ADDR_WIDTH + 1)'(2);
                    end
                end
            end
            STREAM: begin
                if (ptr > {1'b0, particle_count}) begin
                    state_next = DRAIN;
                end else if (credit_ok) begin
                    addr_next = ptr[ADDR_WIDTH-1:0];
                    rden_next = 1'b1;
                    ptr_next  = ptr + (ADDR_WIDTH + 1)'(1);
                    if (ptr == {1'b0, particle_count}) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            wcnt           <= '0;
            cell_addr      <= '0;
            cell_rden      <= 1'b0;
            particle_count <= '0;
        end else begin
            state          <= state_next;
            ptr            <= ptr_next;
            wcnt           <= wcnt_next;
            cell_addr      <= addr_next;
            cell_rden      <= rden_next;
            particle_count <= count_next;
        end
    end

    // Stage p1: read address registered one cycle ago.
    // Stage p2: cell_q now carries the data for idx_p2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= stream_rd;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1 <= cell_addr;
        idx_p2 <= idx_p1;
    end

    assign last_p2 = (idx_p2 == particle_count);

    pos_stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p2),
        .din       ({last_p2, idx_p2, cell_q}),
        .pop       (pop),
        .valid     (out_valid),
        .dout      (fifo_dout),
        .occupancy (occupancy)
    );

    assign out_last = fifo_dout[ENTRY_W-1];
    assign out_idx  = fifo_dout[DATA_WIDTH +: ADDR_WIDTH];
    assign out_pos  = fifo_dout[DATA_WIDTH-1:0];
endmodule
